// File: rtl/uart_transmitter.sv
// UART transmitter: serialises parallel words onto tx as start bit, LSB-first data,
// optional parity and one or two stop bits, paced by an external one-cycle baud strobe.
// One extra word may be accepted during the final stop bit so frames run back to back.
module uart_transmitter #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,  // 0 none, 1 even, 2 odd
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 valid,
  output logic                 ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int unsigned     IdxW     = $clog2(DATA_BITS);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(DATA_BITS - 1);
  localparam logic            LastStop = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StStart,
    StData,
    StPar,
    StStop
  } state_e;

  state_e               state_q, state_d;
  logic                 tx_q, tx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 pending_q, pending_d;
  logic                 par_q, par_d;

  logic accept;
  logic final_stop;
  logic data_par;

  // Parity is taken from the word as handed over, so it is latched alongside it.
  assign data_par   = (PARITY == 2) ? ~(^data) : ^data;
  assign final_stop = (state_q == StStop) && (stop_cnt_q == LastStop);
  assign ready      = (state_q == StIdle) || (final_stop && !pending_q);
  assign accept     = valid && ready;
  assign busy       = (state_q != StIdle);
  assign tx         = tx_q;

  // Next-state, shift and line value; tx only moves on a baud tick.
  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    stop_cnt_d = stop_cnt_q;
    pending_d  = pending_q;
    par_d      = par_q;

    if (accept) begin
      shift_d = data;
      par_d   = data_par;
    end

    case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        // A tick coinciding with the accept is ignored; SYNC waits for the next one.
        if (accept) state_d = StSync;
      end
      StSync: begin
        if (baud_tick) begin
          state_d = StStart;
          tx_d    = 1'b0;
        end
      end
      StStart: begin
        if (baud_tick) begin
          state_d = StData;
          tx_d    = shift_q[0];
          idx_d   = '0;
        end
      end
      StData: begin
        if (baud_tick) begin
          if (idx_q == LastIdx) begin
            if (PARITY != 0) begin
              state_d = StPar;
              tx_d    = par_q;
            end else begin
              state_d    = StStop;
              tx_d       = 1'b1;
              stop_cnt_d = 1'b0;
            end
          end else begin
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
            idx_d   = idx_q + IdxW'(1);
          end
        end
      end
      StPar: begin
        if (baud_tick) begin
          state_d    = StStop;
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
        end
      end
      StStop: begin
        // Early accept without the ending tick just parks the word.
        if (accept && !baud_tick) pending_d = 1'b1;
        if (baud_tick) begin
          if (final_stop) begin
            if (pending_q || accept) begin
              state_d   = StStart;
              tx_d      = 1'b0;
              pending_d = 1'b0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      tx_q       <= 1'b1;
      shift_q    <= '0;
      idx_q      <= '0;
      stop_cnt_q <= 1'b0;
      pending_q  <= 1'b0;
      par_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      stop_cnt_q <= stop_cnt_d;
      pending_q  <= pending_d;
      par_q      <= par_d;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: four instances (8N1, 8E1, 8O1, 8N2) share clock, reset,
// baud strobe and data; each has its own valid. The strobe fires every third clock.
module tb_uart_transmitter;

  logic       clk;
  logic       reset;
  logic       baud_tick;
  logic [7:0] data;
  logic       valid_v [4];
  logic       ready_w [4];
  logic       tx_w    [4];
  logic       busy_w  [4];

  int   checks = 0;
  int   errors = 0;
  int   phase  = 0;
  logic tick_en;
  logic bb_mode;
  int   bb_acc;

  typedef struct {
    int          inst;
    logic [7:0]  d;
    logic [31:0] seq;    // expected tx per bit period, first bit leftmost
    int          nbits;
    string       name;
  } vec_t;

  vec_t vecs [7];

  uart_transmitter #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_n1 (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .data(data), .valid(valid_v[0]),
    .ready(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0])
  );
  uart_transmitter #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_e1 (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .data(data), .valid(valid_v[1]),
    .ready(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1])
  );
  uart_transmitter #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_o1 (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .data(data), .valid(valid_v[2]),
    .ready(ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2])
  );
  uart_transmitter #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_n2 (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .data(data), .valid(valid_v[3]),
    .ready(ready_w[3]), .tx(tx_w[3]), .busy(busy_w[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // One clock; the strobe is high on every third edge. Outputs are sampled 1 unit later.
  task automatic step();
    if (bb_mode && valid_v[0] && ready_w[0]) bb_acc++;
    baud_tick = tick_en && (phase == 2);
    @(posedge clk);
    #1;
    phase = (phase == 2) ? 0 : phase + 1;
    if (bb_mode) begin
      if (bb_acc == 1) data = 8'h80;
      else if (bb_acc >= 2) valid_v[0] = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic send(input int inst, input logic [7:0] d);
    data          = d;
    valid_v[inst] = 1'b1;
    step();
    valid_v[inst] = 1'b0;
  endtask

  // Wait for the start bit, then check each bit value is held for three clocks.
  task automatic check_frame(input int inst, input logic [31:0] seq, input int nbits,
                             input int limit, input string tag);
    int   w;
    logic exp;
    logic act;
    w = 0;
    while (w < 20 && tx_w[inst] !== 1'b0) begin
      step();
      w++;
    end
    if (tx_w[inst] !== 1'b0) begin
      chk({tag, " start"}, tx_w[inst], 1'b0);
      return;
    end
    for (int b = 0; b < limit; b++) begin
      exp = seq[nbits-1-b];
      act = exp;
      for (int k = 0; k < 3; k++) begin
        if (b != 0 || k != 0) step();
        if (k == 0) chk($sformatf("%s busy bit%0d", tag, b), busy_w[inst], 1'b1);
        if (tx_w[inst] !== exp) act = tx_w[inst];
      end
      chk($sformatf("%s tx bit%0d", tag, b), act, exp);
      if (!bb_mode) chk($sformatf("%s ready bit%0d", tag, b), ready_w[inst], (b == nbits - 1));
    end
    if (limit == nbits) begin
      step();
      chk({tag, " idle busy"}, busy_w[inst], 1'b0);
      chk({tag, " idle ready"}, ready_w[inst], 1'b1);
      chk({tag, " idle tx"}, tx_w[inst], 1'b1);
    end
  endtask

  initial begin
    reset     = 1'b1;
    baud_tick = 1'b0;
    data      = 8'h00;
    tick_en   = 1'b1;
    bb_mode   = 1'b0;
    bb_acc    = 0;
    for (int i = 0; i < 4; i++) valid_v[i] = 1'b0;

    vecs[0] = '{0, 8'hA5, 32'b0101001011,  10, "n1_a5"};
    vecs[1] = '{1, 8'hA5, 32'b01010010101, 11, "e1_a5"};
    vecs[2] = '{2, 8'hA5, 32'b01010010111, 11, "o1_a5"};
    vecs[3] = '{1, 8'h07, 32'b01110000011, 11, "e1_07"};
    vecs[4] = '{2, 8'h07, 32'b01110000001, 11, "o1_07"};
    vecs[5] = '{3, 8'h3C, 32'b00011110011, 11, "n2_3c"};
    vecs[6] = '{0, 8'h00, 32'b0000000001,  10, "n1_00"};

    // One-cycle reset, then idle outputs on every instance.
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset tx%0d", i), tx_w[i], 1'b1);
      chk($sformatf("reset ready%0d", i), ready_w[i], 1'b1);
      chk($sformatf("reset busy%0d", i), busy_w[i], 1'b0);
    end

    // Ticks with no valid leave the line idle.
    repeat (9) step();
    chk("ticks idle tx", tx_w[0], 1'b1);
    chk("ticks idle ready", ready_w[0], 1'b1);
    chk("ticks idle busy", busy_w[0], 1'b0);

    // Single frames from the vector table.
    for (int v = 0; v < 7; v++) begin
      do_reset();
      send(vecs[v].inst, vecs[v].d);
      chk({vecs[v].name, " accept busy"}, busy_w[vecs[v].inst], 1'b1);
      chk({vecs[v].name, " accept ready"}, ready_w[vecs[v].inst], 1'b0);
      check_frame(vecs[v].inst, vecs[v].seq, vecs[v].nbits, vecs[v].nbits, vecs[v].name);
    end

    // 8N2: accept lands on a tick edge, which must be ignored.
    do_reset();
    while (phase != 2) step();
    send(3, 8'h3C);
    chk("coinc sync0", tx_w[3], 1'b1);
    step();
    chk("coinc sync1", tx_w[3], 1'b1);
    step();
    chk("coinc sync2", tx_w[3], 1'b1);
    step();
    chk("coinc start", tx_w[3], 1'b0);
    check_frame(3, 32'b00011110011, 11, 11, "coinc");

    // Back-to-back 0x01 then 0x80 with valid held: no gap between frames.
    do_reset();
    bb_mode    = 1'b1;
    bb_acc     = 0;
    data       = 8'h01;
    valid_v[0] = 1'b1;
    check_frame(0, 32'b01000000010000000011, 20, 20, "b2b");
    bb_mode    = 1'b0;
    valid_v[0] = 1'b0;

    // Reset during data bit 3 of 0xA5, then a clean frame.
    do_reset();
    send(0, 8'hA5);
    check_frame(0, 32'b0101001011, 10, 4, "mid");
    step();
    chk("mid bit3 tx", tx_w[0], 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid reset tx", tx_w[0], 1'b1);
    chk("mid reset ready", ready_w[0], 1'b1);
    chk("mid reset busy", busy_w[0], 1'b0);
    send(0, 8'h3C);
    check_frame(0, 32'b0001111001, 10, 10, "post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serial UART transmitter that sits directly downstream of `clock_divider`. It consumes the divider's one-cycle baud strobe and serialises parallel bytes onto a single `tx` line: start bit, LSB-first data, optional parity, then stop bit(s). Upstream logic hands it words over a valid/ready handshake. One frame is in flight at a time, plus one word can be accepted early during the final stop bit so back-to-back frames run with no gap.

## Interface
- `DATA_BITS`, 8: data bits per frame, 5..9.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: stop bits per frame, 1 or 2.
- `clk`  in  1  single system clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `baud_tick`  in  1  one-cycle strobe from `clock_divider`, once per bit period.
- `data`  in  DATA_BITS  word to send; sampled only on handshake.
- `valid`  in  1  upstream has a word on `data`.
- `ready`  out  1  block can accept a word this cycle.
- `tx`  out  1  serial line, registered, idle high.
- `busy`  out  1  a frame is being transmitted or is queued.

## Operation
- States: IDLE, SYNC, START, DATA, PAR, STOP.
- Handshake: a word is accepted when `valid && ready` are both high on a rising edge. `data` is latched into the shift register on that edge.
- IDLE: `tx`=1, `ready`=1, `busy`=0.
  - On accept, go to SYNC. A `baud_tick` in the same cycle is ignored.
- SYNC: `tx`=1. Wait for the next `baud_tick`, then go to START with `tx`=0. This aligns every bit to full tick periods.
- START: on tick, `tx`=shift[0], bit index=0, go to DATA.
- DATA: on each tick, shift right and increment the index.
  - After the tick that ends bit DATA_BITS-1: if PARITY≠0, go to PAR and drive the parity bit. Otherwise go to STOP with `tx`=1.
- Parity bit: XOR of all latched data bits for even; inverted for odd. It is computed from the word as latched, not from the shifted register.
- PAR: on tick, go to STOP with `tx`=1.
- STOP: count STOP_BITS ticks.
  - On the tick that ends the last stop bit: if a word is pending, go to START with `tx`=0; otherwise go to IDLE.
- Early accept: `ready`=1 during the final stop-bit period, while no word is pending.
  - An accept there loads the shift register and parity and sets pending.
  - If accept and the ending tick fall in the same cycle, the new frame's start bit begins on that edge.
- `ready` is 0 in SYNC, START, DATA, PAR, in non-final stop bits, and whenever a word is pending.
- `busy` = (state ≠ IDLE).
- Reset mid-frame abandons the frame and clears pending. On the next edge: `tx`=1, state IDLE.
- Reset values: `tx`=1, `ready`=1, `busy`=0, pending=0, shift register=0, bit index=0, stop count=0.

## Timing
- `tx` is registered and changes only on the edge where `baud_tick`=1 (or on reset).
- Each bit lasts exactly one tick period.
- Latency from accept in IDLE to start bit: up to one tick period, up to the next `baud_tick`. The start bit begins on that tick's edge.
- Frame length is 1 + DATA_BITS + (PARITY≠0) + STOP_BITS tick periods.
- Back-to-back frames with early accept have zero idle bits between the stop and the next start.
- `ready` is a combinational function of state, stop count and pending. It has no dependency on `valid`.
- `baud_tick` pulses wider than one cycle are a protocol violation. Each high cycle counts as a tick.

## Test plan
- Reset/idle:
  - Assert `reset` for one cycle, no `valid` -> `tx`=1, `ready`=1, `busy`=0.
  - Ticks alone -> no change.
- 8N1 frame, tick every 3 clk (15→5 divider): accept 0xA5.
  - `tx` after SYNC = 0,1,0,1,0,0,1,0,1,1. Each value is held 3 clk.
  - `ready` returns during the stop bit; `busy` falls after it.
- Parity, 8E1 then 8O1 with 0xA5:
  - Even: 9th post-start bit = 0.
  - Odd: 9th post-start bit = 1.
  - Frame is 11 bits.
- Back-to-back with `valid` held high, 0x01 then 0x80:
  - Second start bit immediately follows the first stop bit, with no extra idle period.
  - Data bits LSB-first are 1,0,0,0,0,0,0,0 then 0,0,0,0,0,0,0,1.
- STOP_BITS=2, accept coincident with a tick in IDLE:
  - The tick is ignored; start begins on the following tick.
  - Two stop periods of `tx`=1 before `ready` returns to IDLE state.
- Reset mid-frame, during data bit 3:
  - Next edge `tx`=1, `ready`=1, `busy`=0.
  - A new accept afterwards produces a clean full frame.
